// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and defaults for the inter-stage pipeline register.
package pipe_stage_reg_pkg;

  localparam int unsigned PSR_PC_W    = 32;
  localparam int unsigned PSR_DATA_W  = 32;
  localparam int unsigned PSR_EXC_W   = 5;
  localparam int unsigned PSR_STALL_W = 16;

  localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;

  typedef enum logic [1:0] {
    PSR_EMPTY = 2'd0,
    PSR_ONE   = 2'd1,
    PSR_TWO   = 2'd2
  } psr_state_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry register with inject (bubble), clear and load controls.
module pipe_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned     PC_W       = PSR_PC_W,
  parameter int unsigned     DATA_W     = PSR_DATA_W,
  parameter int unsigned     EXC_W      = PSR_EXC_W,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(EXC_HANDLER_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inject,
  input  logic              clear,
  input  logic              load,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_dslot,
  input  logic [EXC_W-1:0]  d_exc,
  input  logic              d_bubble,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data,
  output logic              dslot,
  output logic [EXC_W-1:0]  exc,
  output logic              bubble
);

  // inject > clear > load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      pc     <= '0;
      data   <= '0;
      dslot  <= 1'b0;
      exc    <= '0;
      bubble <= 1'b0;
    end else if (inject) begin
      valid  <= 1'b1;
      pc     <= HANDLER_PC;
      data   <= '0;
      dslot  <= 1'b0;
      exc    <= '0;
      bubble <= 1'b1;
    end else if (clear) begin
      valid  <= 1'b0;
      pc     <= '0;
      data   <= '0;
      dslot  <= 1'b0;
      exc    <= '0;
      bubble <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      pc     <= d_pc;
      data   <= d_data;
      dslot  <= d_dslot;
      exc    <= d_exc;
      bubble <= d_bubble;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, optional skid entry,
// flush, exception-bubble injection and a saturating stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned     PC_W       = PSR_PC_W,
  parameter int unsigned     DATA_W     = PSR_DATA_W,
  parameter int unsigned     EXC_W      = PSR_EXC_W,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(EXC_HANDLER_PC),
  parameter int unsigned     SKID       = 1,
  parameter int unsigned     STALL_W    = PSR_STALL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               req,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_dslot,
  input  logic [EXC_W-1:0]   in_exc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_dslot,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bubble,
  output logic [STALL_W-1:0] stall_cnt
);

  psr_state_e state, state_nxt;

  logic main_load, main_clear, main_inject, main_from_skid;
  logic skid_load, skid_clear;
  logic xfer_in, xfer_out;

  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic              skid_dslot;
  logic [EXC_W-1:0]  skid_exc;
  logic              skid_bubble;

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PSR_EMPTY;
    else        state <= state_nxt;
  end

  // Next state and slot controls; req beats flush beats handshake.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_inject    = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (req) begin
      state_nxt   = PSR_ONE;
      main_inject = 1'b1;
      skid_clear  = 1'b1;
    end else if (flush) begin
      state_nxt  = PSR_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        PSR_EMPTY: begin
          if (xfer_in) begin
            state_nxt = PSR_ONE;
            main_load = 1'b1;
          end
        end
        PSR_ONE: begin
          if (xfer_out && xfer_in) begin
            main_load = 1'b1;
          end else if (xfer_out) begin
            state_nxt  = PSR_EMPTY;
            main_clear = 1'b1;
          end else if (xfer_in && SKID != 0) begin
            state_nxt = PSR_TWO;
            skid_load = 1'b1;
          end
        end
        PSR_TWO: begin
          if (xfer_out) begin
            state_nxt      = PSR_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: state_nxt = PSR_EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W), .HANDLER_PC(HANDLER_PC)
  ) u_main (
    .clk      (clk),
    .reset    (reset),
    .inject   (main_inject),
    .clear    (main_clear),
    .load     (main_load),
    .d_pc     (main_from_skid ? skid_pc     : in_pc),
    .d_data   (main_from_skid ? skid_data   : in_data),
    .d_dslot  (main_from_skid ? skid_dslot  : in_dslot),
    .d_exc    (main_from_skid ? skid_exc    : in_exc),
    .d_bubble (main_from_skid ? skid_bubble : 1'b0),
    .valid    (out_valid),
    .pc       (out_pc),
    .data     (out_data),
    .dslot    (out_dslot),
    .exc      (out_exc),
    .bubble   (out_bubble)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W), .HANDLER_PC(HANDLER_PC)
    ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .inject   (1'b0),
      .clear    (skid_clear),
      .load     (skid_load),
      .d_pc     (in_pc),
      .d_data   (in_data),
      .d_dslot  (in_dslot),
      .d_exc    (in_exc),
      .d_bubble (1'b0),
      .valid    (skid_valid),
      .pc       (skid_pc),
      .data     (skid_data),
      .dslot    (skid_dslot),
      .exc      (skid_exc),
      .bubble   (skid_bubble)
    );
    // Straight off the skid valid flop, so never a function of out_ready.
    assign in_ready = ~skid_valid;
  end else begin : g_noskid
    assign skid_valid  = 1'b0;
    assign skid_pc     = '0;
    assign skid_data   = '0;
    assign skid_dslot  = 1'b0;
    assign skid_exc    = '0;
    assign skid_bubble = 1'b0;
    assign in_ready    = ~out_valid | out_ready | skid_valid;
  end

  // Saturating count of back-pressured cycles; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + STALL_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid build and a single-entry build with a
// 2-bit stall counter share stimulus, each checked against a FIFO model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        dslot;
    logic [4:0]  exc;
    logic        bubble;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, req, in_valid, out_ready, in_dslot;
  logic [31:0] in_pc, in_data;
  logic [4:0]  in_exc;

  logic        o_ir  [2];
  logic        o_v   [2];
  logic [31:0] o_pc  [2];
  logic [31:0] o_data[2];
  logic        o_ds  [2];
  logic [4:0]  o_exc [2];
  logic        o_bub [2];
  logic [15:0] st0;
  logic [1:0]  st1;

  int n_checks = 0;
  int n_pass   = 0;

  ent_t        m_e[2][2];
  int          m_n[2];
  logic [15:0] m_st[2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1), .STALL_W(16)) u_s1 (
    .clk(clk), .reset(reset), .flush(flush), .req(req),
    .in_valid(in_valid), .in_ready(o_ir[0]), .in_pc(in_pc), .in_data(in_data),
    .in_dslot(in_dslot), .in_exc(in_exc),
    .out_valid(o_v[0]), .out_ready(out_ready), .out_pc(o_pc[0]), .out_data(o_data[0]),
    .out_dslot(o_ds[0]), .out_exc(o_exc[0]), .out_bubble(o_bub[0]), .stall_cnt(st0)
  );

  pipe_stage_reg #(.SKID(0), .STALL_W(2)) u_s0 (
    .clk(clk), .reset(reset), .flush(flush), .req(req),
    .in_valid(in_valid), .in_ready(o_ir[1]), .in_pc(in_pc), .in_data(in_data),
    .in_dslot(in_dslot), .in_exc(in_exc),
    .out_valid(o_v[1]), .out_ready(out_ready), .out_pc(o_pc[1]), .out_data(o_data[1]),
    .out_dslot(o_ds[1]), .out_exc(o_exc[1]), .out_bubble(o_bub[1]), .stall_cnt(st1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  function automatic logic exp_in_ready(input int i);
    if (i == 0) return m_n[i] < 2;
    return (m_n[i] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i]  = 0;
      m_st[i] = '0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic ir;
      logic [15:0] smax;
      ir   = exp_in_ready(i);
      smax = (i == 0) ? 16'hFFFF : 16'd3;
      if (m_n[i] > 0 && !out_ready && m_st[i] != smax) m_st[i] = m_st[i] + 16'd1;
      if (req) begin
        m_n[i]    = 1;
        m_e[i][0] = {32'h0000_4180, 32'h0, 1'b0, 5'h0, 1'b1};
      end else if (flush) begin
        m_n[i] = 0;
      end else begin
        if (m_n[i] > 0 && out_ready) begin
          m_e[i][0] = m_e[i][1];
          m_n[i]    = m_n[i] - 1;
        end
        if (in_valid && ir) begin
          m_e[i][m_n[i]] = {in_pc, in_data, in_dslot, in_exc, 1'b0};
          m_n[i]         = m_n[i] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      ent_t e;
      logic [15:0] st;
      e  = (m_n[i] > 0) ? m_e[i][0] : '0;
      st = (i == 0) ? st0 : {14'b0, st1};
      chk($sformatf("s%0d.in_ready", i),   64'(o_ir[i]),   64'(exp_in_ready(i)));
      chk($sformatf("s%0d.out_valid", i),  64'(o_v[i]),    64'(m_n[i] > 0));
      chk($sformatf("s%0d.out_pc", i),     64'(o_pc[i]),   64'(e.pc));
      chk($sformatf("s%0d.out_data", i),   64'(o_data[i]), 64'(e.data));
      chk($sformatf("s%0d.out_dslot", i),  64'(o_ds[i]),   64'(e.dslot));
      chk($sformatf("s%0d.out_exc", i),    64'(o_exc[i]),  64'(e.exc));
      chk($sformatf("s%0d.out_bubble", i), 64'(o_bub[i]),  64'(e.bubble));
      chk($sformatf("s%0d.stall_cnt", i),  64'(st),        64'(m_st[i]));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] data,
                       input logic ordy, input logic fl, input logic rq);
    in_valid  = v;
    in_pc     = pc;
    in_data   = data;
    in_dslot  = 1'($urandom_range(0, 1));
    in_exc    = 5'($urandom);
    out_ready = ordy;
    flush     = fl;
    req       = rq;
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;

    // Single-cycle latency and one-per-cycle streaming.
    drive(1'b1, 32'h3000, 32'h2408_0001, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("t1.first_pc", 64'(o_pc[0]), 64'h3000);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 32'h3000 + 32'(4 * k), $urandom, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(); cycle();

    // Back-pressure fills the skid; drain keeps FIFO order.
    drive(1'b1, 32'h3000, 32'h11, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h3004, 32'h22, 1'b0, 1'b0, 1'b0); cycle();
    chk("t2.in_ready_two", 64'(o_ir[0]), 64'h0);
    chk("t2.head_pc", 64'(o_pc[0]), 64'h3000);
    drive(1'b1, 32'h3008, 32'h33, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("t2.second_pc", 64'(o_pc[0]), 64'h3004);
    cycle(); cycle();

    // Stall counting and saturation.
    pulse_reset();
    drive(1'b1, 32'h3100, 32'h44, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle();
    chk("t3.stall5", 64'(st0), 64'd5);
    cycle();
    chk("t3.stall_sat", 64'(st1), 64'd3);

    // Flush while full with a same-edge input.
    drive(1'b1, 32'h3200, 32'h55, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h5000, 32'h66, 1'b0, 1'b1, 1'b0); cycle();
    chk("t4.flush_valid", 64'(o_v[0]), 64'h0);
    chk("t4.flush_ready", 64'(o_ir[0]), 64'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(); cycle();

    // req wins over flush in the full state.
    drive(1'b1, 32'h3300, 32'h77, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h3304, 32'h88, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h3308, 32'h99, 1'b0, 1'b1, 1'b1); cycle();
    chk("t5.bubble_pc", 64'(o_pc[0]), 64'h4180);
    chk("t5.bubble_flag", 64'(o_bub[0]), 64'h1);
    chk("t5.skid_empty", 64'(o_ir[0]), 64'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(); cycle();

    // Async reset between edges mid-stream.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h3400 + 32'(4 * k), $urandom, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    #2 reset = 1'b0;
    #1;
    chk("t6.async_valid0", 64'(o_v[0]), 64'h0);
    chk("t6.async_pc0", 64'(o_pc[0]), 64'h0);
    chk("t6.async_valid1", 64'(o_v[1]), 64'h0);
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 24) == 0));
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
